sdf_stage_ctrl: RTL and testbench

Sequencing controller for one radix-2 single-path delay-feedback (R2SDF) stage of the 32-point FFT pipeline. It drives the stage's DELAY-deep shift-register delay line and butterfly mux.
- Counts samples within a frame.
- Selects fill/butterfly phase.
- Flushes the delay line after the last frame.
- Generates output-valid, frame count and overrun status.
One instance sits beside each SDF stage (DELAY = 16, 8, 4, 2, 1).

---
 rtl/sdf_stage_ctrl.sv | 154 +++++++++++++++
 tb/tb_sdf_stage_ctrl.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/sdf_stage_ctrl.sv
// sdf_stage_ctrl: fill / butterfly / drain sequencer for one radix-2 SDF FFT stage.
// Define SDF_TW_ADDR_EN to generate the registered twiddle-ROM address on tw_addr.
module sdf_stage_ctrl #(
  parameter int LOG2_DELAY = 3,
  parameter int FRAME_W    = 8,
  parameter int TW_SHIFT   = 0
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               in_valid,
  output logic               in_ready,
  output logic               shift_en,
  output logic               bf_sel,
  output logic               out_valid,
  output logic [FRAME_W-1:0] frame_cnt,
  output logic               overrun,
  output logic [4:0]         tw_addr
);

  localparam int                 CW         = LOG2_DELAY + 1;
  localparam logic [CW-1:0]      CNT_ZERO   = CW'(0);
  localparam logic [CW-1:0]      CNT_ONE    = CW'(1);
  localparam logic [CW-1:0]      DELAY_M1   = CW'((1 << LOG2_DELAY) - 1);
  localparam logic [CW-1:0]      CNT_LAST   = CW'((2 << LOG2_DELAY) - 1);
  localparam logic [FRAME_W-1:0] FRAME_ZERO = FRAME_W'(0);
  localparam logic [FRAME_W-1:0] FRAME_ONE  = FRAME_W'(1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FILL  = 2'd1,
    RUN   = 2'd2,
    DRAIN = 2'd3
  } state_t;

  state_t             state_r;
  logic [CW-1:0]      cnt_r;
  logic               out_valid_r;
  logic [FRAME_W-1:0] frame_cnt_r;
  logic               overrun_r;

  logic in_ready_s;
  logic accept_s;
  logic drain_start_s;
  logic shift_s;
  logic emit_s;
  logic bf_sel_s;

  // Handshake, shift and phase decode. A RUN cycle that idles on a frame
  // boundary is already the first forced drain shift, so the drain follows the
  // last sample with no bubble and still spans exactly DELAY shifts.
  always_comb begin
    in_ready_s    = (state_r != DRAIN);
    accept_s      = in_valid & in_ready_s;
    drain_start_s = (state_r == RUN) && (cnt_r == CNT_ZERO) && !in_valid;
    shift_s       = accept_s | drain_start_s | (state_r == DRAIN);
    emit_s        = shift_s && ((state_r == RUN) || (state_r == DRAIN));
    if ((state_r == FILL) || (state_r == RUN)) begin
      bf_sel_s = cnt_r[LOG2_DELAY];
    end else begin
      bf_sel_s = 1'b0;
    end
  end

  // Sequencer state, sample counter and status registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r     <= IDLE;
      cnt_r       <= CNT_ZERO;
      out_valid_r <= 1'b0;
      frame_cnt_r <= FRAME_ZERO;
      overrun_r   <= 1'b0;
    end else begin
      out_valid_r <= emit_s;
      if (in_valid && !in_ready_s) begin
        overrun_r <= 1'b1;
      end
      if (shift_s && (state_r == RUN) && (cnt_r == CNT_LAST)) begin
        frame_cnt_r <= frame_cnt_r + FRAME_ONE;
      end
      case (state_r)
        IDLE, FILL: begin
          if (accept_s) begin
            cnt_r   <= cnt_r + CNT_ONE;
            state_r <= (cnt_r == DELAY_M1) ? RUN : FILL;
          end
        end
        RUN: begin
          if (drain_start_s) begin
            if (cnt_r == DELAY_M1) begin
              state_r <= IDLE;
              cnt_r   <= CNT_ZERO;
            end else begin
              state_r <= DRAIN;
              cnt_r   <= cnt_r + CNT_ONE;
            end
          end else if (accept_s) begin
            cnt_r <= cnt_r + CNT_ONE;
          end
        end
        DRAIN: begin
          if (cnt_r == DELAY_M1) begin
            state_r <= IDLE;
            cnt_r   <= CNT_ZERO;
          end else begin
            cnt_r <= cnt_r + CNT_ONE;
          end
        end
        default: begin
          state_r <= IDLE;
          cnt_r   <= CNT_ZERO;
        end
      endcase
    end
  end

`ifdef SDF_TW_ADDR_EN
  localparam logic [4:0] TW_MASK = 5'((1 << LOG2_DELAY) - 1);

  logic [4:0] tw_addr_r;
  logic [4:0] tw_next_s;

  // Difference-half outputs carry a twiddle index; everything else is index 0
  always_comb begin
    if (emit_s && !bf_sel_s) begin
      tw_next_s = (5'(cnt_r) & TW_MASK) << TW_SHIFT;
    end else begin
      tw_next_s = 5'd0;
    end
  end

  // Twiddle address register, updated with each shift so it lines up with out_valid
  always_ff @(posedge clk) begin
    if (reset) begin
      tw_addr_r <= 5'd0;
    end else if (shift_s) begin
      tw_addr_r <= tw_next_s;
    end else begin
      tw_addr_r <= tw_addr_r;
    end
  end

  assign tw_addr = tw_addr_r;
`else
  assign tw_addr = 5'd0 << TW_SHIFT;
`endif

  assign in_ready  = in_ready_s;
  assign shift_en  = shift_s;
  assign bf_sel    = bf_sel_s;
  assign out_valid = out_valid_r;
  assign frame_cnt = frame_cnt_r;
  assign overrun   = overrun_r;

endmodule

// File: tb/tb_sdf_stage_ctrl.sv
// Self-checking bench for sdf_stage_ctrl (DELAY = 8) against a sample-count reference model.
module tb_sdf_stage_ctrl;

  localparam int LOG2_DELAY = 3;
  localparam int D          = 1 << LOG2_DELAY;
  localparam int TW_SHIFT   = 4 - LOG2_DELAY;
`ifdef SDF_TW_ADDR_EN
  localparam bit TW_EN = 1'b1;
`else
  localparam bit TW_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset;
  logic       in_valid;
  logic       in_ready;
  logic       shift_en;
  logic       bf_sel;
  logic       out_valid;
  logic [7:0] frame_cnt;
  logic       overrun;
  logic [4:0] tw_addr;

  sdf_stage_ctrl #(
    .LOG2_DELAY(LOG2_DELAY),
    .FRAME_W   (8),
    .TW_SHIFT  (TW_SHIFT)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .shift_en (shift_en),
    .bf_sel   (bf_sel),
    .out_valid(out_valid),
    .frame_cnt(frame_cnt),
    .overrun  (overrun),
    .tw_addr  (tw_addr)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model: samples accepted in the current stream, forced drain shifts
  // still owed, and the registered outputs as they will appear next cycle.
  int         m_n;
  int         m_drain;
  logic       m_ov;
  logic       m_ovr;
  logic [7:0] m_frame;
  logic [4:0] m_tw;

  function automatic logic [4:0] tw_model(input int k);
    int t;
    t = (k % D) << TW_SHIFT;
    return 5'(t);
  endfunction

  // Output vector layout: {in_ready, shift_en, bf_sel, out_valid, frame_cnt[7:0], overrun, tw_addr[4:0]}
  task automatic model_cycle(input logic v, output logic [17:0] e);
    logic       rdy, start, sh, bf, emit;
    int         pos;
    logic [4:0] ntw;
    rdy   = (m_drain == 0);
    pos   = m_n % (2 * D);
    start = rdy && !v && (m_n >= 2 * D) && (pos == 0);
    sh    = !rdy || v || start;
    bf    = rdy && (pos >= D);
    e     = {rdy, sh, bf, m_ov, m_frame, m_ovr, m_tw};
    emit  = 1'b0;
    ntw   = 5'd0;
    if (!rdy) begin
      emit = 1'b1;
      ntw  = tw_model(D - m_drain);
      m_drain = m_drain - 1;
    end else if (v) begin
      emit = (m_n >= D);
      if (emit && !bf) ntw = tw_model(pos);
      if (emit && (pos == 2 * D - 1)) m_frame = m_frame + 8'd1;
      m_n = m_n + 1;
    end else if (start) begin
      emit    = 1'b1;
      ntw     = tw_model(0);
      m_drain = D - 1;
      m_n     = 0;
    end
    m_ovr = m_ovr | (v & !rdy);
    m_ov  = emit;
    if (sh && TW_EN) m_tw = ntw;
  endtask

  task automatic run_cycle(input logic v, output logic [17:0] o, output logic [17:0] e);
    model_cycle(v, e);
    in_valid = v;
    @(negedge clk);
    o = {in_ready, shift_en, bf_sel, out_valid, frame_cnt, overrun, tw_addr};
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset(input logic v);
    reset    = 1'b1;
    in_valid = v;
    @(posedge clk);
    #1;
    reset    = 1'b0;
    in_valid = 1'b0;
    m_n = 0; m_drain = 0; m_ov = 1'b0; m_ovr = 1'b0; m_frame = 8'd0; m_tw = 5'd0;
  endtask

  // One 16-sample stream from cycle 0 with the absolute cycle timing of a single frame
  task automatic run_frame16(input string tag);
    logic [17:0] o, e;
    int pulses = 0;
    for (int c = 0; c < 30; c++) begin
      run_cycle(c < 16, o, e);
      n_checks++;
      if (o !== e) $display("FAIL %s_model cyc %0d: got %h expected %h", tag, c, o, e);
      else n_pass++;
      n_checks++;
      if ({o[16], o[15], o[14]} !== {(c <= 23), (c >= 8 && c <= 15), (c >= 9 && c <= 24)})
        $display("FAIL %s_timing cyc %0d: got sh/bf/ov %b%b%b", tag, c, o[16], o[15], o[14]);
      else n_pass++;
      if (o[14]) pulses++;
    end
    n_checks++;
    if (pulses !== 16) $display("FAIL %s_pulses: got %0d expected 16", tag, pulses);
    else n_pass++;
    n_checks++;
    if ({frame_cnt, in_ready, shift_en} !== {8'd1, 1'b1, 1'b0})
      $display("FAIL %s_end: got frame %0d rdy %b sh %b expected frame 1 rdy 1 sh 0", tag, frame_cnt, in_ready, shift_en);
    else n_pass++;
  endtask

  task automatic test_reset();
    logic [17:0] o, e;
    apply_reset(1'b1);
    run_cycle(1'b0, o, e);
    n_checks++;
    if (o !== 18'h20000) $display("FAIL reset_state: got %h expected %h", o, 18'h20000);
    else n_pass++;
    n_checks++;
    if (o !== e) $display("FAIL reset_model: got %h expected %h", o, e);
    else n_pass++;
  endtask

  task automatic test_single_frame();
    apply_reset(1'b0);
    run_frame16("single_frame");
  endtask

  task automatic test_back_to_back();
    logic [17:0] o, e;
    apply_reset(1'b0);
    for (int c = 0; c < 46; c++) begin
      run_cycle(c < 32, o, e);
      n_checks++;
      if (o !== e) $display("FAIL b2b_model cyc %0d: got %h expected %h", c, o, e);
      else n_pass++;
      n_checks++;
      if (o[14] !== (c >= 9 && c <= 40)) $display("FAIL b2b_out_valid cyc %0d: got %b", c, o[14]);
      else n_pass++;
    end
    n_checks++;
    if (frame_cnt !== 8'd2) $display("FAIL b2b_frames: got %0d expected 2", frame_cnt);
    else n_pass++;
  endtask

  task automatic test_stall();
    logic [17:0] o, e;
    int pulses = 0;
    apply_reset(1'b0);
    for (int c = 0; c < 36; c++) begin
      run_cycle((c < 19) && !(c >= 11 && c <= 13), o, e);
      n_checks++;
      if (o !== e) $display("FAIL stall_model cyc %0d: got %h expected %h", c, o, e);
      else n_pass++;
      if (c >= 11 && c <= 13) begin
        n_checks++;
        if (o[16:15] !== 2'b01) $display("FAIL stall_hold cyc %0d: got sh/bf %b expected 01", c, o[16:15]);
        else n_pass++;
      end
      if (o[14]) pulses++;
    end
    n_checks++;
    if (pulses !== 16) $display("FAIL stall_pulses: got %0d expected 16", pulses);
    else n_pass++;
  endtask

  task automatic test_overrun();
    logic [17:0] o, e;
    int drain_shifts = 0;
    apply_reset(1'b0);
    for (int c = 0; c < 36; c++) begin
      run_cycle((c < 16) || (c == 17), o, e);
      n_checks++;
      if (o !== e) $display("FAIL overrun_model cyc %0d: got %h expected %h", c, o, e);
      else n_pass++;
      if (c == 17) begin
        n_checks++;
        if (o[17] !== 1'b0) $display("FAIL overrun_ready: got %b expected 0", o[17]);
        else n_pass++;
      end
      if (c >= 16 && o[16]) drain_shifts++;
    end
    n_checks++;
    if (drain_shifts !== D) $display("FAIL overrun_drain: got %0d expected %0d", drain_shifts, D);
    else n_pass++;
    n_checks++;
    if ({overrun, frame_cnt} !== {1'b1, 8'd1})
      $display("FAIL overrun_sticky: got ovr %b frame %0d expected ovr 1 frame 1", overrun, frame_cnt);
    else n_pass++;
  endtask

  task automatic test_reset_mid_run();
    logic [17:0] o, e;
    apply_reset(1'b0);
    for (int c = 0; c < 11; c++) begin
      run_cycle(1'b1, o, e);
      n_checks++;
      if (o !== e) $display("FAIL midrst_model cyc %0d: got %h expected %h", c, o, e);
      else n_pass++;
    end
    apply_reset(1'b1);
    run_frame16("after_reset");
  endtask

  task automatic test_random();
    logic [17:0] o, e;
    logic v;
    int guard = 0;
    apply_reset(1'b0);
    for (int c = 0; c < 600; c++) begin
      run_cycle($urandom_range(0, 99) < 75, o, e);
      n_checks++;
      if (o !== e) $display("FAIL random_model cyc %0d: got %h expected %h", c, o, e);
      else n_pass++;
    end
    while ((m_n != 0 || m_drain != 0) && guard < 100) begin
      v = (m_drain == 0) && !((m_n >= 2 * D) && ((m_n % (2 * D)) == 0));
      run_cycle(v, o, e);
      n_checks++;
      if (o !== e) $display("FAIL random_flush cyc %0d: got %h expected %h", guard, o, e);
      else n_pass++;
      guard++;
    end
    run_cycle(1'b0, o, e);
    n_checks++;
    if (o !== e) $display("FAIL random_idle: got %h expected %h", o, e);
    else n_pass++;
  endtask

  initial begin
    reset    = 1'b1;
    in_valid = 1'b0;
    test_reset();
    test_single_frame();
    test_back_to_back();
    test_stall();
    test_overrun();
    test_reset_mid_run();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not reach the summary");
    $fatal(1);
  end

endmodule
